// File: rtl/multi_byte_instruction_register.sv
// Multi-byte instruction register: assembles BYTES W-bus transfers (opcode first)
// into one instruction word. Optional parity checking is enabled with IR_PARITY_EN.
module multi_byte_instruction_register #(
    parameter int BUS_W = 8,
    parameter int OPC_W = 4,
    parameter int BYTES = 2
) (
    input  logic                           clk,
    input  logic                           clr_n,
    input  logic                           li_n,
    input  logic                           ei_n,
    input  logic                           flush_n,
    input  logic [BUS_W-1:0]               w_bus,
`ifdef IR_PARITY_EN
    input  logic                           par_in,
    output logic                           par_err,
`endif
    output logic [BUS_W-1:0]               out_bus,
    output logic [OPC_W-1:0]               op_code,
    output logic [BUS_W*BYTES-OPC_W-1:0]   operand,
    output logic [2:0]                     byte_cnt,
    output logic                           ir_ready
);

    localparam int          IW   = BUS_W * BYTES;
    localparam int          OW   = IW - OPC_W;
    localparam logic [2:0]  FULL = 3'(BYTES);

    // Slot k of the instruction lives in ir_bytes[BYTES-1-k], so slot 0 is the MSB byte.
    logic [BYTES-1:0][BUS_W-1:0] ir_bytes;
    logic [IW-1:0]               ir;
    logic                        full;
    logic [BUS_W-1:0]            out_val;

    assign ir   = ir_bytes;
    assign full = (byte_cnt == FULL);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ir_bytes <= '0;
            byte_cnt <= '0;
        end else if (!flush_n) begin
            ir_bytes <= '0;
            byte_cnt <= '0;
        end else if (!li_n) begin
            if (full) begin
                // A load on a complete instruction starts the next fetch directly.
                ir_bytes            <= '0;
                ir_bytes[BYTES-1]   <= w_bus;
                byte_cnt            <= 3'd1;
            end else begin
                for (int k = 0; k < BYTES; k++) begin
                    if (byte_cnt == 3'(k)) begin
                        ir_bytes[BYTES-1-k] <= w_bus;
                    end
                end
                byte_cnt <= byte_cnt + 3'd1;
            end
        end
    end

`ifdef IR_PARITY_EN
    logic bad_par;

    assign bad_par = (^w_bus) != par_in;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            par_err <= 1'b0;
        end else if (!flush_n) begin
            par_err <= 1'b0;
        end else if (!li_n) begin
            if (full) begin
                par_err <= bad_par;
            end else begin
                par_err <= par_err | bad_par;
            end
        end
    end

    assign ir_ready = full & ~par_err;
`else
    assign ir_ready = full;
`endif

    assign op_code = ir[IW-1 -: OPC_W];
    assign operand = ir[OW-1:0];

    // Narrow operands (e.g. the single-byte SAP-1 case) are zero-extended onto the bus.
    generate
        if (OW >= BUS_W) begin : g_trunc
            assign out_val = operand[BUS_W-1:0];
        end else begin : g_zext
            assign out_val = {{(BUS_W-OW){1'b0}}, operand};
        end
    endgenerate

    assign out_bus = (!ei_n && ir_ready) ? out_val : {BUS_W{1'bz}};

endmodule
